// File: rtl/data_memory_pkg.sv
// Shared defaults and the lane-word type for the word-addressed data memory.
package data_memory_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned MEM_SIZE  = 10020;
  localparam int unsigned VEC_SIZE  = 1;

  typedef logic [DATA_SIZE-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: vecSize consecutive lanes per access, combinational
// read, single-edge write, asynchronous clear of the whole array on reset.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned dataSize       = DATA_SIZE,
  parameter int unsigned addressingSize = ADDR_SIZE,
  parameter int unsigned memorySize     = MEM_SIZE,
  parameter int unsigned vecSize        = VEC_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_enable,
  input  logic [addressingSize-1:0]    DataAdr,
  input  logic [vecSize*dataSize-1:0]  toWrite_data,
  output logic [vecSize*dataSize-1:0]  read_data
);

  localparam int unsigned LANE_AW = addressingSize + 1;
  localparam int unsigned IDX_W   = (memorySize > 1) ? $clog2(memorySize) : 1;
  localparam int unsigned LANE_IW = (vecSize > 1) ? $clog2(vecSize) : 1;

  logic [dataSize-1:0] r_mem [memorySize];

  logic [LANE_AW-1:0]  w_lane_adr   [vecSize];
  logic [IDX_W-1:0]    w_lane_idx   [vecSize];
  logic                w_lane_ok    [vecSize];
  logic [dataSize-1:0] w_lane_wdata [vecSize];

  // Lane addresses carry one extra bit so DataAdr+i never wraps back into range.
  for (genvar gi = 0; gi < vecSize; gi++) begin : g_lane
    assign w_lane_adr[gi]   = LANE_AW'(DataAdr) + LANE_AW'(gi);
    assign w_lane_ok[gi]    = (w_lane_adr[gi] < LANE_AW'(memorySize));
    assign w_lane_idx[gi]   = IDX_W'(w_lane_adr[gi]);
    assign w_lane_wdata[gi] = toWrite_data[gi*dataSize +: dataSize];
    assign read_data[gi*dataSize +: dataSize] =
      w_lane_ok[gi] ? r_mem[w_lane_idx[gi]] : '0;
  end

  // Single writer process for all lanes; out-of-range lanes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < memorySize; i++) begin
        r_mem[IDX_W'(i)] <= '0;
      end
    end else if (write_enable) begin
      for (int unsigned l = 0; l < vecSize; l++) begin
        if (w_lane_ok[LANE_IW'(l)]) begin
          r_mem[w_lane_idx[LANE_IW'(l)]] <= w_lane_wdata[LANE_IW'(l)];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: single-lane vector table plus multi-lane and reset sequences.
module tb_data_memory;
  import data_memory_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         we1;
  logic [31:0]  adr1;
  logic [31:0]  wd1;
  logic [31:0]  rd1;
  logic         we4;
  logic [31:0]  adr4;
  logic [127:0] wd4;
  logic [127:0] rd4;

  int n_cmp;
  int n_bad;

  data_memory u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (we1),
    .DataAdr      (adr1),
    .toWrite_data (wd1),
    .read_data    (rd1)
  );

  data_memory #(.vecSize(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (we4),
    .DataAdr      (adr4),
    .toWrite_data (wd4),
    .read_data    (rd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{"idle_after_reset", 1'b0, 32'd100,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1]  = '{"write_100",        1'b1, 32'd100,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{"read_100",         1'b0, 32'd100,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{"read_101",         1'b0, 32'd101,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{"write_last",       1'b1, 32'd10019,      32'h12345678, 32'h0,        32'h12345678};
    vecs[5]  = '{"write_oob",        1'b1, 32'd10020,      32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[6]  = '{"read_last",        1'b0, 32'd10019,      32'h0,        32'h12345678, 32'h12345678};
    vecs[7]  = '{"read_oob",         1'b0, 32'd10020,      32'h0,        32'h0,        32'h0};
    vecs[8]  = '{"write_5_a",        1'b1, 32'd5,          32'h0000000A, 32'h0,        32'h0000000A};
    vecs[9]  = '{"rdw_5_b",          1'b1, 32'd5,          32'h0000000B, 32'h0000000A, 32'h0000000B};
    vecs[10] = '{"we0_no_change",    1'b0, 32'd5,          32'hCAFEF00D, 32'h0000000B, 32'h0000000B};
    vecs[11] = '{"write_0",          1'b1, 32'd0,          32'h11111111, 32'h0,        32'h11111111};
    vecs[12] = '{"read_max_adr",     1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        32'h0};
    vecs[13] = '{"write_max_adr",    1'b1, 32'hFFFFFFFF,   32'h22222222, 32'h0,        32'h0};
    vecs[14] = '{"no_wrap_to_0",     1'b0, 32'd0,          32'h0,        32'h11111111, 32'h11111111};

    rst_n = 1'b0;
    we1 = 1'b0; adr1 = 32'd100; wd1 = '0;
    we4 = 1'b0; adr4 = 32'd0;   wd4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", 128'(rd1), 128'h0);
    chk("reset_rd4", rd4, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      we1 = vecs[i].we; adr1 = vecs[i].adr; wd1 = vecs[i].wd;
      #1;
      chk({vecs[i].name, "_pre"}, 128'(rd1), 128'(vecs[i].exp_pre));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_post"}, 128'(rd1), 128'(vecs[i].exp_post));
    end
    @(negedge clk);
    we1 = 1'b0;

    // Four lanes straddling the end of the array.
    we4 = 1'b1; adr4 = 32'd10018;
    wd4 = {32'd4, 32'd3, 32'd2, 32'd1};
    @(posedge clk);
    #1;
    chk("vec4_write_edge", rd4, {32'd0, 32'd0, 32'd2, 32'd1});
    @(negedge clk);
    we4 = 1'b0;
    #1;
    chk("vec4_read_10018", rd4, {32'd0, 32'd0, 32'd2, 32'd1});
    adr4 = 32'd10016;
    #1;
    chk("vec4_read_10016", rd4, {32'd2, 32'd1, 32'd0, 32'd0});

    // Asynchronous clear between edges, writes ignored while held.
    adr1 = 32'd100;
    #1;
    chk("pre_reset_100", 128'(rd1), 128'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_clear_100", 128'(rd1), 128'h0);
    chk("async_clear_vec4", rd4, 128'h0);
    we1 = 1'b1; wd1 = 32'h55555555;
    @(posedge clk);
    #1;
    chk("write_in_reset", 128'(rd1), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_release", 128'(rd1), 128'h0);
    @(posedge clk);
    #1;
    chk("first_write_after", 128'(rd1), 128'h55555555);
    @(negedge clk);
    we1 = 1'b0;
    adr1 = 32'd5;
    #1;
    chk("cleared_5", 128'(rd1), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
